// File: rtl/uart_serial_transceiver.sv
// Pin-level UART transmitter/receiver (8N1) timed by a 16x oversampling tick from a clock divisor.
// Define UART_PARITY_EN for 8E1 framing with an extra rx_parity_err pulse output.
module uart_serial_transceiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned RX_IDLE_FILTER = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] divisor,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [7:0]  rx_data,
  output logic        rx_done,
  output logic        rx_frame_err,
`ifdef UART_PARITY_EN
  output logic        rx_parity_err,
`endif
  input  logic [7:0]  tx_data,
  input  logic        tx_wr,
  output logic        tx_busy,
  output logic        tx_done,
  input  logic        break_en
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SYNC_W = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef UART_PARITY_EN
  localparam int unsigned TX_BITS = 11;
`else
  localparam int unsigned TX_BITS = 10;
`endif

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_STOP   = 3'd3;
`ifdef UART_PARITY_EN
  localparam logic [2:0] RX_PARITY = 3'd4;
`endif
  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;

  // 16x tick: reload on zero, so a divisor change lands at the next reload
  logic [15:0] tick_cnt;
  logic        tick;
  assign tick = (tick_cnt == 16'd0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)   tick_cnt <= '0;
    else if (tick) tick_cnt <= (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    else           tick_cnt <= tick_cnt - 16'd1;
  end

  logic [SYNC_W-1:0] rx_sync;
  logic              rxs;
  assign rxs = rx_sync[SYNC_W-1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rx_sync <= '1;
    else         rx_sync <= {rx_sync[SYNC_W-2:0], uart_rx};
  end

  logic [2:0]        rx_state, rx_state_d;
  logic [CNT_W-1:0]  rx_tcnt, rx_tcnt_d;
  logic [2:0]        rx_bcnt, rx_bcnt_d;
  logic [DATA_W-1:0] rx_shift, rx_shift_d, rx_data_d;
  logic              rx_done_d, rx_ferr_d;
`ifdef UART_PARITY_EN
  logic              rx_perr_flag, rx_perr_flag_d, rx_perr_d;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state     <= RX_IDLE;
      rx_tcnt      <= '0;
      rx_bcnt      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_flag  <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_state     <= rx_state_d;
      rx_tcnt      <= rx_tcnt_d;
      rx_bcnt      <= rx_bcnt_d;
      rx_shift     <= rx_shift_d;
      rx_data      <= rx_data_d;
      rx_done      <= rx_done_d;
      rx_frame_err <= rx_ferr_d;
`ifdef UART_PARITY_EN
      rx_perr_flag  <= rx_perr_flag_d;
      rx_parity_err <= rx_perr_d;
`endif
    end
  end

  // Receiver: mid-bit sampling, 8 ticks into start then every 16 ticks
  always_comb begin
    rx_state_d = rx_state;
    rx_tcnt_d  = rx_tcnt;
    rx_bcnt_d  = rx_bcnt;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    rx_done_d  = 1'b0;
    rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_flag_d = rx_perr_flag;
    rx_perr_d      = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (tick && !rxs) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd7) begin
            rx_tcnt_d  = '0;
            rx_bcnt_d  = '0;
            rx_state_d = (rxs && (RX_IDLE_FILTER != 0)) ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'hF) begin
            rx_shift_d = {rxs, rx_shift[DATA_W-1:1]};
            rx_bcnt_d  = rx_bcnt + 3'd1;
`ifdef UART_PARITY_EN
            if (rx_bcnt == 3'd7) rx_state_d = RX_PARITY;
`else
            if (rx_bcnt == 3'd7) rx_state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'hF) begin
            rx_perr_flag_d = rxs ^ (^rx_shift);
            rx_state_d     = RX_STOP;
          end
        end
      end
`endif
      RX_STOP: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'hF) begin
            rx_data_d  = rx_shift;
            rx_done_d  = 1'b1;
            rx_ferr_d  = ~rxs;
`ifdef UART_PARITY_EN
            rx_perr_d  = rx_perr_flag;
`endif
            rx_state_d = RX_IDLE;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  logic [0:0]         tx_state, tx_state_d;
  logic [TX_BITS-1:0] tx_shift, tx_shift_d, tx_frame;
  logic [CNT_W-1:0]   tx_tcnt, tx_tcnt_d, tx_bcnt, tx_bcnt_d;
  logic               tx_busy_d, tx_done_d, uart_tx_d;

`ifdef UART_PARITY_EN
  assign tx_frame = {1'b1, ^tx_data, tx_data, 1'b0};
`else
  assign tx_frame = {1'b1, tx_data, 1'b0};
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_shift <= tx_shift_d;
      tx_tcnt  <= tx_tcnt_d;
      tx_bcnt  <= tx_bcnt_d;
      tx_busy  <= tx_busy_d;
      tx_done  <= tx_done_d;
      uart_tx  <= uart_tx_d;
    end
  end

  // Transmitter: busy covers the tx_done cycle so a write coinciding with it is dropped
  always_comb begin
    tx_state_d = tx_state;
    tx_shift_d = tx_shift;
    tx_tcnt_d  = tx_tcnt;
    tx_bcnt_d  = tx_bcnt;
    tx_busy_d  = tx_busy;
    tx_done_d  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_busy_d = 1'b0;
        if (tx_wr && !tx_busy) begin
          tx_shift_d = tx_frame;
          tx_state_d = TX_SHIFT;
          tx_tcnt_d  = '0;
          tx_bcnt_d  = '0;
          tx_busy_d  = 1'b1;
        end
      end
      TX_SHIFT: begin
        tx_busy_d = 1'b1;
        if (tick) begin
          tx_tcnt_d = tx_tcnt + 4'd1;
          if (tx_tcnt == 4'hF) begin
            if (tx_bcnt == 4'(TX_BITS - 1)) begin
              tx_state_d = TX_IDLE;
              tx_done_d  = 1'b1;
              tx_shift_d = '1;
            end else begin
              tx_shift_d = {1'b1, tx_shift[TX_BITS-1:1]};
              tx_bcnt_d  = tx_bcnt + 4'd1;
            end
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    uart_tx_d = tx_shift_d[0] & ~break_en;
  end

endmodule

// File: tb/tb_uart_serial_transceiver.sv
// Directed bench for uart_serial_transceiver: TX framing/timing, RX framing, glitch filter, break, reset.
module tb_uart_serial_transceiver;
  logic        sys_clk;
  logic        sys_rst;
  logic [15:0] divisor;
  logic        uart_rx;
  logic        uart_tx;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_frame_err;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        tx_done;
  logic        break_en;

  logic        nf_uart_tx;
  logic [7:0]  nf_rx_data;
  logic        nf_rx_done;
  logic        nf_rx_frame_err;
  logic [7:0]  nf_tx_data;
  logic        nf_tx_wr;
  logic        nf_tx_busy;
  logic        nf_tx_done;
  logic        nf_break_en;
`ifdef UART_PARITY_EN
  logic        rx_parity_err;
  logic        nf_rx_parity_err;
`endif

  int          checks;
  int          failures;
  int unsigned cyc;
  logic [7:0]  rxq_data[$];
  logic        rxq_ferr[$];
  int          nf_cnt;
  logic [7:0]  nf_last;
  logic        nf_last_ferr;
  int          txd_cnt;

  uart_serial_transceiver #(.SYNC_STAGES(2), .RX_IDLE_FILTER(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .divisor(divisor), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .rx_data(rx_data), .rx_done(rx_done), .rx_frame_err(rx_frame_err),
`ifdef UART_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .tx_done(tx_done), .break_en(break_en)
  );

  uart_serial_transceiver #(.SYNC_STAGES(2), .RX_IDLE_FILTER(0)) dut_nf (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .divisor(divisor), .uart_rx(uart_rx),
    .uart_tx(nf_uart_tx), .rx_data(nf_rx_data), .rx_done(nf_rx_done), .rx_frame_err(nf_rx_frame_err),
`ifdef UART_PARITY_EN
    .rx_parity_err(nf_rx_parity_err),
`endif
    .tx_data(nf_tx_data), .tx_wr(nf_tx_wr), .tx_busy(nf_tx_busy), .tx_done(nf_tx_done), .break_en(nf_break_en)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Record every done pulse for the tests to inspect afterwards
  always @(negedge sys_clk) begin
    if (rx_done === 1'b1) begin
      rxq_data.push_back(rx_data);
      rxq_ferr.push_back(rx_frame_err);
    end
    if (nf_rx_done === 1'b1) begin
      nf_cnt++;
      nf_last      = nf_rx_data;
      nf_last_ferr = nf_rx_frame_err;
    end
    if (tx_done === 1'b1) txd_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_rx(input logic [9:0] frame, input int bitc);
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      wait_cyc(bitc);
    end
    uart_rx = 1'b1;
  endtask

  task automatic capture_tx(input int bitc, output logic [7:0] b, output logic stopb);
    int w;
    w = 0;
    b = '0;
    stopb = 1'b0;
    while (uart_tx !== 1'b0 && w < 4000) begin
      w++;
      @(negedge sys_clk);
    end
    checks++;
    if (uart_tx !== 1'b0) begin
      failures++;
      $display("FAIL tx_start_timeout got=%b exp=0", uart_tx);
    end else begin
      wait_cyc(bitc / 2);
      for (int i = 0; i < 8; i++) begin
        wait_cyc(bitc);
        b[i] = uart_tx;
      end
      wait_cyc(bitc);
      stopb = uart_tx;
    end
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    wait_cyc(3);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL rst_uart_tx got=%b exp=1", uart_tx); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL rst_rx_done got=%b exp=0", rx_done); end
    checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL rst_rx_frame_err got=%b exp=0", rx_frame_err); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rst_tx_busy got=%b exp=0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL rst_tx_done got=%b exp=0", tx_done); end
    sys_rst = 1'b0;
    wait_cyc(2);
    checks++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("FAIL post_rst_idle got tx=%b busy=%b exp tx=1 busy=0", uart_tx, tx_busy); end
  endtask

  task automatic test_tx_frame;
    int unsigned c0;
    int len, bad_busy, n, d0;
    logic lvl;
    divisor = 16'd27;
    wait_cyc(60);
    checks++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("FAIL tx_idle got tx=%b busy=%b exp tx=1 busy=0", uart_tx, tx_busy); end
    d0 = txd_cnt;
    tx_data = 8'h55;
    tx_wr = 1'b1;
    c0 = cyc;
    @(negedge sys_clk);
    tx_wr = 1'b0;
    bad_busy = 0;
    lvl = 1'b0;
    // 0x55 framed is 0,1,0,1,...: measure each constant run as one bit period
    for (int i = 0; i < 9; i++) begin
      len = 0;
      while (uart_tx === lvl && len < 600) begin
        if (tx_busy !== 1'b1) bad_busy++;
        len++;
        @(negedge sys_clk);
      end
      checks++;
      if ((i == 0 && (len < 400 || len > 433)) || (i > 0 && (len < 420 || len > 444))) begin
        failures++;
        $display("FAIL tx55_bit%0d_len got=%0d exp=%0d", i, len, 432);
      end
      lvl = ~lvl;
    end
    while (tx_done !== 1'b1 && (cyc - c0) < 5000) begin
      if (tx_busy !== 1'b1) bad_busy++;
      @(negedge sys_clk);
    end
    n = int'(cyc - c0);
    checks++; if (n < 4290 || n > 4325) begin failures++; $display("FAIL tx55_done_time got=%0d exp=%0d", n, 4320); end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL tx55_busy_low got=%0d exp=0", bad_busy); end
    wait_cyc(30);
    checks++; if (txd_cnt - d0 != 1) begin failures++; $display("FAIL tx55_done_count got=%0d exp=1", txd_cnt - d0); end
    checks++; if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin failures++; $display("FAIL tx55_end_idle got tx=%b busy=%b exp tx=1 busy=0", uart_tx, tx_busy); end
  endtask

  task automatic test_rx_frame;
    rxq_data.delete();
    rxq_ferr.delete();
    send_rx({1'b1, 8'hA3, 1'b0}, 432);
    wait_cyc(432);
    checks++;
    if (rxq_data.size() != 1) begin
      failures++;
      $display("FAIL rxA3_done_count got=%0d exp=1", rxq_data.size());
    end else begin
      checks++; if (rxq_data[0] !== 8'hA3) begin failures++; $display("FAIL rxA3_data got=%h exp=a3", rxq_data[0]); end
      checks++; if (rxq_ferr[0] !== 1'b0) begin failures++; $display("FAIL rxA3_ferr got=%b exp=0", rxq_ferr[0]); end
    end
  endtask

  task automatic test_frame_err;
    divisor = 16'd4;
    wait_cyc(60);
    rxq_data.delete();
    rxq_ferr.delete();
    send_rx({1'b0, 8'h3C, 1'b0}, 64);
    wait_cyc(12 * 64);
    checks++;
    if (rxq_data.size() != 1) begin
      failures++;
      $display("FAIL ferr_done_count got=%0d exp=1", rxq_data.size());
    end else begin
      checks++; if (rxq_data[0] !== 8'h3C) begin failures++; $display("FAIL ferr_data got=%h exp=3c", rxq_data[0]); end
      checks++; if (rxq_ferr[0] !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", rxq_ferr[0]); end
    end
  endtask

  task automatic test_break_rx;
    rxq_data.delete();
    rxq_ferr.delete();
    uart_rx = 1'b0;
    wait_cyc(22 * 64);
    uart_rx = 1'b1;
    wait_cyc(14 * 64);
    checks++;
    if (rxq_data.size() < 2) begin
      failures++;
      $display("FAIL brk_rx_frames got=%0d exp=2", rxq_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rxq_data[i] !== 8'h00 || rxq_ferr[i] !== 1'b1) begin
          failures++;
          $display("FAIL brk_rx_frame%0d got data=%h ferr=%b exp data=00 ferr=1", i, rxq_data[i], rxq_ferr[i]);
        end
      end
    end
  endtask

  task automatic test_glitch_filter;
    int n0;
    rxq_data.delete();
    rxq_ferr.delete();
    n0 = nf_cnt;
    wait_cyc(10);
    uart_rx = 1'b0;
    wait_cyc(12);
    uart_rx = 1'b1;
    wait_cyc(12 * 64);
    checks++; if (rxq_data.size() != 0) begin failures++; $display("FAIL glitch_filtered got=%0d exp=0", rxq_data.size()); end
    checks++; if (nf_cnt - n0 != 1) begin failures++; $display("FAIL glitch_nofilter_count got=%0d exp=1", nf_cnt - n0); end
    checks++; if (nf_last !== 8'hFF || nf_last_ferr !== 1'b0) begin failures++; $display("FAIL glitch_nofilter_data got=%h ferr=%b exp=ff ferr=0", nf_last, nf_last_ferr); end
  endtask

  task automatic test_back_to_back;
    int unsigned c0;
    int n, d0, low;
    logic [7:0] b;
    logic sb;
    d0 = txd_cnt;
    tx_data = 8'h11;
    tx_wr = 1'b1;
    c0 = cyc;
    @(negedge sys_clk);
    tx_wr = 1'b0;
    fork
      capture_tx(64, b, sb);
      begin
        wait_cyc(200);
        tx_data = 8'h22;
        tx_wr = 1'b1;
        @(negedge sys_clk);
        tx_wr = 1'b0;
      end
    join
    checks++; if (b !== 8'h11 || sb !== 1'b1) begin failures++; $display("FAIL b2b_first_byte got=%h stop=%b exp=11 stop=1", b, sb); end
    while (tx_done !== 1'b1 && (cyc - c0) < 2000) @(negedge sys_clk);
    n = int'(cyc - c0);
    checks++; if (n < 630 || n > 645) begin failures++; $display("FAIL b2b_done_time got=%0d exp=%0d", n, 640); end
    // write in the same cycle as tx_done must be dropped
    tx_data = 8'h77;
    tx_wr = 1'b1;
    @(negedge sys_clk);
    tx_wr = 1'b0;
    low = 0;
    repeat (800) begin
      @(negedge sys_clk);
      if (uart_tx !== 1'b1) low++;
    end
    checks++; if (low != 0) begin failures++; $display("FAIL b2b_no_second_frame got=%0d exp=0", low); end
    checks++; if (txd_cnt - d0 != 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", txd_cnt - d0); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
  endtask

  task automatic test_break_tx;
    int unsigned c0;
    int n, d0, hi;
    divisor = 16'd8;
    wait_cyc(60);
    d0 = txd_cnt;
    tx_data = 8'hFF;
    tx_wr = 1'b1;
    c0 = cyc;
    @(negedge sys_clk);
    tx_wr = 1'b0;
    wait_cyc(150);
    break_en = 1'b1;
    hi = 0;
    repeat (1000) begin
      @(negedge sys_clk);
      if (uart_tx !== 1'b0) hi++;
    end
    break_en = 1'b0;
    checks++; if (hi != 0) begin failures++; $display("FAIL brk_tx_low got=%0d exp=0", hi); end
    wait_cyc(2);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL brk_tx_release got=%b exp=1", uart_tx); end
    while (tx_done !== 1'b1 && (cyc - c0) < 3000) @(negedge sys_clk);
    n = int'(cyc - c0);
    checks++; if (n < 1270 || n > 1285) begin failures++; $display("FAIL brk_tx_done_time got=%0d exp=%0d", n, 1280); end
    wait_cyc(5);
    checks++; if (txd_cnt - d0 != 1) begin failures++; $display("FAIL brk_tx_done_count got=%0d exp=1", txd_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int d0;
    divisor = 16'd4;
    wait_cyc(60);
    rxq_data.delete();
    rxq_ferr.delete();
    d0 = txd_cnt;
    tx_data = 8'hA5;
    tx_wr = 1'b1;
    @(negedge sys_clk);
    tx_wr = 1'b0;
    uart_rx = 1'b0;
    wait_cyc(300);
    checks++; if (tx_busy !== 1'b1 || uart_tx !== 1'b0) begin failures++; $display("FAIL midrst_pre got busy=%b tx=%b exp busy=1 tx=0", tx_busy, uart_tx); end
    sys_rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge sys_clk);
    checks++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("FAIL midrst_next got tx=%b busy=%b exp tx=1 busy=0", uart_tx, tx_busy); end
    sys_rst = 1'b0;
    wait_cyc(1000);
    checks++; if (rxq_data.size() != 0) begin failures++; $display("FAIL midrst_rx_done got=%0d exp=0", rxq_data.size()); end
    checks++; if (txd_cnt - d0 != 0) begin failures++; $display("FAIL midrst_tx_done got=%0d exp=0", txd_cnt - d0); end
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", uart_tx); end
  endtask

  task automatic test_div0;
    int unsigned c0;
    int n;
    logic [7:0] b;
    logic sb;
    divisor = 16'd0;
    wait_cyc(60);
    tx_data = 8'h5A;
    tx_wr = 1'b1;
    c0 = cyc;
    @(negedge sys_clk);
    tx_wr = 1'b0;
    capture_tx(16, b, sb);
    checks++; if (b !== 8'h5A || sb !== 1'b1) begin failures++; $display("FAIL div0_byte got=%h stop=%b exp=5a stop=1", b, sb); end
    while (tx_done !== 1'b1 && (cyc - c0) < 1000) @(negedge sys_clk);
    n = int'(cyc - c0);
    checks++; if (n != 161) begin failures++; $display("FAIL div0_done_time got=%0d exp=161", n); end
  endtask

  initial begin
    sys_rst     = 1'b1;
    divisor     = 16'd27;
    uart_rx     = 1'b1;
    tx_data     = 8'h00;
    tx_wr       = 1'b0;
    break_en    = 1'b0;
    nf_tx_data  = 8'h00;
    nf_tx_wr    = 1'b0;
    nf_break_en = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_tx_frame();
    test_rx_frame();
    test_frame_err();
    test_break_rx();
    test_glitch_filter();
    test_back_to_back();
    test_break_tx();
    test_reset_mid();
    test_div0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
